// File: rtl/assoc_cmd_issuer_if.sv
// assoc_cmd_issuer_if: request, buffer-command and response signals of the command issuer
//   master: environment side (drives requests, buffer results, response ready)
//   slave : issuer side (drives cmd_ready, buffer command, response payload)
//   cmd_*  : valid/ready request channel (op 00 NOP, 01 LOAD, 10 INCR, 11 LOOKUP)
//   buf_*  : one-cycle command to associative_buffer and its registered result
//   rsp_*  : valid/ready response channel carrying key, data and hit
interface assoc_cmd_issuer_if #(
    parameter int KEY_WIDTH  = 2,
    parameter int DATA_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [KEY_WIDTH-1:0]  cmd_key;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [1:0]            buf_ctrl;
    logic [KEY_WIDTH-1:0]  buf_key;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [DATA_WIDTH-1:0] buf_data_output;
    logic                  buf_valid;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [KEY_WIDTH-1:0]  rsp_key;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_hit;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_data, buf_data_output, buf_valid, rsp_ready,
        input  cmd_ready, buf_ctrl, buf_key, buf_data, rsp_valid, rsp_key, rsp_data, rsp_hit
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_data, buf_data_output, buf_valid, rsp_ready,
        output cmd_ready, buf_ctrl, buf_key, buf_data, rsp_valid, rsp_key, rsp_data, rsp_hit
    );
endinterface

// File: rtl/assoc_cmd_issuer.sv
// assoc_cmd_issuer: FIFO-queued, in-order command front-end for associative_buffer
//   clk : single clock, rising edge
//   rst : asynchronous active-low reset
//   bus : assoc_cmd_issuer_if.slave (cmd_* request in, buf_* command out / result in, rsp_* response out)
//   ASSOC_ISSUER_LOAD_ACK_EN (macro): when defined, LOAD also waits for and returns a response
module assoc_cmd_issuer #(
    parameter int KEY_WIDTH  = 2,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    assoc_cmd_issuer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    logic [1:0]            r_op_mem   [DEPTH];
    logic [KEY_WIDTH-1:0]  r_key_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_cmd_ready;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_buf_ctrl;
    logic [KEY_WIDTH-1:0]  r_buf_key;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic [KEY_WIDTH-1:0]  r_rsp_key;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_hit;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_rsp_valid;
    logic                  w_empty;
    logic                  w_needs_rsp;
    logic                  w_next_issues;
    logic [AW:0]           w_count_nxt;
    logic [1:0]            w_head_op;
    logic [KEY_WIDTH-1:0]  w_head_key;
    logic [DATA_WIDTH-1:0] w_head_data;

    // r_buf_ctrl is only non-NOP while in ISSUE, so it identifies the op being issued.
`ifdef ASSOC_ISSUER_LOAD_ACK_EN
    assign w_needs_rsp = r_buf_ctrl != OP_NOP;
`else
    assign w_needs_rsp = r_buf_ctrl[1];
`endif

    assign w_push        = bus.cmd_valid & r_cmd_ready;
    assign w_empty       = r_count == '0;
    assign w_head_op     = r_op_mem[r_rd_ptr];
    assign w_head_key    = r_key_mem[r_rd_ptr];
    assign w_head_data   = r_data_mem[r_rd_ptr];
    assign w_count_nxt   = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    // A popped NOP is dropped, so the FSM only enters ISSUE for a real command.
    assign w_next_issues = !w_empty && w_head_op != OP_NOP;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]   <= bus.cmd_op;
            r_key_mem[r_wr_ptr]  <= bus.cmd_key;
            r_data_mem[r_wr_ptr] <= bus.cmd_data;
        end
    end

    // cmd_ready is registered from the post-edge occupancy; a full FIFO refuses a push even on a pop cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_wr_ptr    <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr    <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count     <= w_count_nxt;
            r_cmd_ready <= w_count_nxt != (AW+1)'(DEPTH);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  w_state_nxt = w_next_issues ? ISSUE : IDLE;
            ISSUE: w_state_nxt = w_needs_rsp ? WAIT : (w_next_issues ? ISSUE : IDLE);
            WAIT:  w_state_nxt = RESP;
            RESP:  w_state_nxt = !bus.rsp_ready ? RESP : (w_next_issues ? ISSUE : IDLE);
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_capture   = r_state == WAIT;
        w_rsp_valid = r_state == RESP;
        if (!w_empty)
            w_pop = r_state == IDLE || (r_state == ISSUE && !w_needs_rsp) || (r_state == RESP && bus.rsp_ready);
    end

    // Popping loads the command register that drives the buffer; ctrl returns to NOP on any other cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_ctrl <= OP_NOP;
            r_buf_key  <= '0;
            r_buf_data <= '0;
            r_rsp_key  <= '0;
            r_rsp_data <= '0;
            r_rsp_hit  <= 1'b0;
        end else begin
            r_buf_ctrl <= w_pop ? w_head_op : OP_NOP;
            if (w_pop && w_head_op != OP_NOP) begin
                r_buf_key  <= w_head_key;
                r_buf_data <= w_head_data;
            end
            if (w_capture) begin
                r_rsp_key  <= r_buf_key;
                r_rsp_data <= bus.buf_data_output;
                r_rsp_hit  <= bus.buf_valid;
            end
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.buf_ctrl  = r_buf_ctrl;
    assign bus.buf_key   = r_buf_key;
    assign bus.buf_data  = r_buf_data;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_key   = r_rsp_key;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_hit   = r_rsp_hit;
endmodule

// File: tb/tb_assoc_cmd_issuer.sv
// tb_assoc_cmd_issuer: directed table-driven bench for assoc_cmd_issuer with a behavioural associative buffer
module tb_assoc_cmd_issuer;
    localparam int KW = 2;
    localparam int DW = 4;
`ifdef ASSOC_ISSUER_LOAD_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    typedef struct {
        logic [1:0]    op;
        logic [KW-1:0] key;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_data;
        logic          exp_hit;
    } vec_t;
    typedef struct {
        logic [1:0]    ctrl;
        logic [KW-1:0] key;
        logic [DW-1:0] data;
        int            cyc;
    } trace_t;
    typedef struct {
        logic [KW-1:0] key;
        logic [DW-1:0] data;
        logic          hit;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    trace_t tq[$];
    rsp_t   rq[$];
    vec_t   vt[14];
    logic [DW-1:0] mem_d [4];
    logic [3:0]    mem_v;

    always #5 clk = ~clk;

    assoc_cmd_issuer_if #(.KEY_WIDTH(KW), .DATA_WIDTH(DW)) bus();
    assoc_cmd_issuer #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Buffer model: result registered on the edge that samples ctrl.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_v               <= '0;
            bus.buf_data_output <= '0;
            bus.buf_valid       <= 1'b0;
        end else begin
            case (bus.buf_ctrl)
                2'b01: begin
                    mem_d[bus.buf_key]  <= bus.buf_data;
                    mem_v[bus.buf_key]  <= 1'b1;
                    bus.buf_data_output <= bus.buf_data;
                    bus.buf_valid       <= 1'b1;
                end
                2'b10: begin
                    if (mem_v[bus.buf_key]) mem_d[bus.buf_key] <= mem_d[bus.buf_key] + 4'd1;
                    bus.buf_data_output <= mem_v[bus.buf_key] ? mem_d[bus.buf_key] + 4'd1 : 4'd0;
                    bus.buf_valid       <= mem_v[bus.buf_key];
                end
                2'b11: begin
                    bus.buf_data_output <= mem_v[bus.buf_key] ? mem_d[bus.buf_key] : 4'd0;
                    bus.buf_valid       <= mem_v[bus.buf_key];
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (bus.buf_ctrl != 2'b00) tq.push_back('{ctrl: bus.buf_ctrl, key: bus.buf_key, data: bus.buf_data, cyc: cyc});
            if (bus.rsp_valid && bus.rsp_ready) rq.push_back('{key: bus.rsp_key, data: bus.rsp_data, hit: bus.rsp_hit});
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [KW-1:0] key, input logic [DW-1:0] data);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_key   = key;
        bus.cmd_data  = data;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            if (++n > 50) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic clear_q();
        tq.delete();
        rq.delete();
    endtask

    initial begin
        logic [KW-1:0] bp_keys[5];
        logic [DW-1:0] bp_data[5];
        bp_keys = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
        bp_data = '{4'd3, 4'd1, 4'd4, 4'd2, 4'd3};
        vt[0]  = '{2'd1, 2'd1, 4'hE, 4'hE, 1'b1};
        vt[1]  = '{2'd3, 2'd1, 4'h0, 4'hE, 1'b1};
        vt[2]  = '{2'd2, 2'd1, 4'h0, 4'hF, 1'b1};
        vt[3]  = '{2'd3, 2'd2, 4'h0, 4'h0, 1'b0};
        vt[4]  = '{2'd0, 2'd3, 4'h5, 4'h0, 1'b0};
        vt[5]  = '{2'd1, 2'd3, 4'h7, 4'h7, 1'b1};
        vt[6]  = '{2'd2, 2'd3, 4'h0, 4'h8, 1'b1};
        vt[7]  = '{2'd2, 2'd3, 4'h0, 4'h9, 1'b1};
        vt[8]  = '{2'd3, 2'd3, 4'h0, 4'h9, 1'b1};
        vt[9]  = '{2'd2, 2'd0, 4'h0, 4'h0, 1'b0};
        vt[10] = '{2'd2, 2'd1, 4'h0, 4'h0, 1'b1};
        vt[11] = '{2'd3, 2'd1, 4'h0, 4'h0, 1'b1};
        vt[12] = '{2'd1, 2'd2, 4'hA, 4'hA, 1'b1};
        vt[13] = '{2'd3, 2'd2, 4'h0, 4'hA, 1'b1};
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_key   = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
        chk("rst_buf_ctrl", int'(bus.buf_ctrl), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", int'(bus.cmd_ready), 1);

        for (int i = 0; i < 14; i++) begin
            int exp_nr;
            clear_q();
            push(vt[i].op, vt[i].key, vt[i].data);
            repeat (6) @(posedge clk);
            #1;
            exp_nr = int'(vt[i].op[1] | (ACK & vt[i].op == 2'd1));
            chk($sformatf("v%0d_ctrl_cnt", i), tq.size(), int'(vt[i].op != 2'd0));
            if (tq.size() == 1) begin
                chk($sformatf("v%0d_ctrl", i), int'(tq[0].ctrl), int'(vt[i].op));
                chk($sformatf("v%0d_bkey", i), int'(tq[0].key), int'(vt[i].key));
                chk($sformatf("v%0d_bdata", i), int'(tq[0].data), int'(vt[i].data));
            end
            chk($sformatf("v%0d_rsp_cnt", i), rq.size(), exp_nr);
            if (rq.size() == 1) begin
                chk($sformatf("v%0d_rkey", i), int'(rq[0].key), int'(vt[i].key));
                chk($sformatf("v%0d_rdata", i), int'(rq[0].data), int'(vt[i].exp_data));
                chk($sformatf("v%0d_rhit", i), int'(rq[0].hit), int'(vt[i].exp_hit));
            end
        end

        // Latency: push at edge N, ctrl live N+1..N+2, rsp_valid at N+3.
        clear_q();
        push(2'd3, 2'd2, 4'd0);
        chk("lat_n_ctrl", int'(bus.buf_ctrl), 0);
        @(posedge clk); #1;
        chk("lat_n1_ctrl", int'(bus.buf_ctrl), 3);
        chk("lat_n1_key", int'(bus.buf_key), 2);
        chk("lat_n1_rv", int'(bus.rsp_valid), 0);
        @(posedge clk); #1;
        chk("lat_n2_ctrl", int'(bus.buf_ctrl), 0);
        chk("lat_n2_rv", int'(bus.rsp_valid), 0);
        @(posedge clk); #1;
        chk("lat_n3_rv", int'(bus.rsp_valid), 1);
        chk("lat_n3_data", int'(bus.rsp_data), 10);
        chk("lat_n3_hit", int'(bus.rsp_hit), 1);
        @(posedge clk); #1;
        chk("lat_n4_rv", int'(bus.rsp_valid), 0);

        // Back-to-back LOADs.
        repeat (3) @(posedge clk);
        #1;
        clear_q();
        for (int i = 0; i < 4; i++) push(2'd1, KW'(i), DW'(i + 1));
        repeat (15) @(posedge clk);
        #1;
        chk("b2b_cnt", tq.size(), 4);
        if (tq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("b2b%0d_ctrl", i), int'(tq[i].ctrl), 1);
                chk($sformatf("b2b%0d_key", i), int'(tq[i].key), i);
                chk($sformatf("b2b%0d_data", i), int'(tq[i].data), i + 1);
                if (i > 0) chk($sformatf("b2b%0d_gap", i), tq[i].cyc - tq[i-1].cyc, ACK ? 3 : 1);
            end
        end
        chk("b2b_rsp_cnt", rq.size(), ACK ? 4 : 0);

        // NOP between two LOOKUPs.
        clear_q();
        push(2'd3, 2'd0, 4'd0);
        push(2'd0, 2'd1, 4'd9);
        push(2'd3, 2'd3, 4'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("nop_ctrl_cnt", tq.size(), 2);
        if (tq.size() == 2) begin
            chk("nop_k0", int'(tq[0].key), 0);
            chk("nop_k1", int'(tq[1].key), 3);
            chk("nop_c1", int'(tq[1].ctrl), 3);
        end
        chk("nop_rsp_cnt", rq.size(), 2);
        if (rq.size() == 2) begin
            chk("nop_r0", int'(rq[0].data), 1);
            chk("nop_r1", int'(rq[1].data), 4);
        end

        // Back-pressure: one in RESP, four queued, FIFO full.
        clear_q();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(2'd3, bp_keys[i], 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_cmd_ready", int'(bus.cmd_ready), 0);
        chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
        chk("bp_rsp_key_held", int'(bus.rsp_key), 2);
        chk("bp_rsp_none", rq.size(), 0);
        bus.rsp_ready = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("bp_rsp_cnt", rq.size(), 5);
        if (rq.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("bp%0d_key", i), int'(rq[i].key), int'(bp_keys[i]));
                chk($sformatf("bp%0d_data", i), int'(rq[i].data), int'(bp_data[i]));
                chk($sformatf("bp%0d_hit", i), int'(rq[i].hit), 1);
            end
        end
        chk("bp_cmd_ready_after", int'(bus.cmd_ready), 1);

        // Asynchronous reset with a response pending and commands queued.
        clear_q();
        bus.rsp_ready = 1'b0;
        push(2'd3, 2'd1, 4'd0);
        push(2'd3, 2'd2, 4'd0);
        push(2'd3, 2'd3, 4'd0);
        @(posedge clk); #1;
        chk("mid_rsp_valid", int'(bus.rsp_valid), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", int'(bus.cmd_ready), 0);
        chk("mid_rst_buf_ctrl", int'(bus.buf_ctrl), 0);
        chk("mid_rst_buf_key", int'(bus.buf_key), 0);
        chk("mid_rst_buf_data", int'(bus.buf_data), 0);
        chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("mid_rst_rsp_key", int'(bus.rsp_key), 0);
        chk("mid_rst_rsp_data", int'(bus.rsp_data), 0);
        chk("mid_rst_rsp_hit", int'(bus.rsp_hit), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        clear_q();
        @(posedge clk); #1;
        chk("rel_cmd_ready", int'(bus.cmd_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("rel_no_ctrl", tq.size(), 0);
        chk("rel_no_rsp", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
